// File: rtl/msg_injector_pkg.sv
// Shared types and sizing for the message injector.
package msg_injector_pkg;

    typedef enum logic [1:0] {IDLE, PASS, INJ} inj_state_t;

    localparam int DATA_W          = 32;
    localparam int MAX_PENDING_DEF = 4;

    function automatic int pend_w(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

    localparam int PEND_W = pend_w(MAX_PENDING_DEF);

endpackage

// File: rtl/avalon_st_out_reg.sv
// One-entry valid/ready output register; holds its word until the sink takes it.
module avalon_st_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] in_data,
    input  logic         in_sop,
    input  logic         in_eop,
    input  logic         out_ready,
    output logic         can_load,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_sop,
    output logic         out_eop
);

    assign can_load = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else if (can_load) begin
            out_valid <= load;
            out_sop   <= load && in_sop;
            out_eop   <= load && in_eop;
            if (load) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/msg_injector.sv
// Merges whole messages from inj_in into the msg_in stream, only at message boundaries.
module msg_injector
    import msg_injector_pkg::*;
#(
    parameter int MAX_PENDING = MAX_PENDING_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inject,
    input  logic              msg_in_valid,
    output logic              msg_in_ready,
    input  logic              msg_in_sop,
    input  logic              msg_in_eop,
    input  logic [DATA_W-1:0] msg_in_data,
    input  logic              inj_in_valid,
    output logic              inj_in_ready,
    input  logic              inj_in_sop,
    input  logic              inj_in_eop,
    input  logic [DATA_W-1:0] inj_in_data,
    output logic              msg_out_valid,
    input  logic              msg_out_ready,
    output logic              msg_out_sop,
    output logic              msg_out_eop,
    output logic [DATA_W-1:0] msg_out_data,
    output logic              inject_indication,
    output logic              protocol_error
);

    localparam int PW = pend_w(MAX_PENDING);

    inj_state_t        state;
    logic [PW-1:0]     pending;
    logic              ready_en;
    logic              can_load;
    logic              inj_avail, sel_inj, sel_msg, at_boundary;
    logic              acc, bad_word, load, inj_sop_acc, pend_inc;
    logic              w_sop, w_eop;
    logic [DATA_W-1:0] w_data;

    always_comb begin
        at_boundary  = (state == IDLE);
        inj_avail    = (pending != '0) && inj_in_valid;
        sel_inj      = (state == INJ) || (at_boundary && inj_avail);
        sel_msg      = (state == PASS) || (at_boundary && !inj_avail);
        // ready_en keeps both readies low until the first clock after reset release
        inj_in_ready = ready_en && sel_inj && can_load;
        msg_in_ready = ready_en && sel_msg && can_load;
        w_sop        = sel_inj ? inj_in_sop  : msg_in_sop;
        w_eop        = sel_inj ? inj_in_eop  : msg_in_eop;
        w_data       = sel_inj ? inj_in_data : msg_in_data;
        acc          = (inj_in_valid && inj_in_ready) || (msg_in_valid && msg_in_ready);
        bad_word     = acc && at_boundary && !w_sop;
        load         = acc && !bad_word;
        inj_sop_acc  = acc && sel_inj && at_boundary && w_sop;
        pend_inc     = inject && (pending != PW'(MAX_PENDING));
    end

    avalon_st_out_reg #(.W(DATA_W)) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .in_data   (w_data),
        .in_sop    (w_sop),
        .in_eop    (w_eop),
        .out_ready (msg_out_ready),
        .can_load  (can_load),
        .out_valid (msg_out_valid),
        .out_data  (msg_out_data),
        .out_sop   (msg_out_sop),
        .out_eop   (msg_out_eop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            pending           <= '0;
            ready_en          <= 1'b0;
            inject_indication <= 1'b0;
            protocol_error    <= 1'b0;
        end else begin
            ready_en          <= 1'b1;
            inject_indication <= inj_sop_acc;
            protocol_error    <= bad_word;

            if (pend_inc && !inj_sop_acc) begin
                pending <= pending + PW'(1);
            end else if (inj_sop_acc && !pend_inc) begin
                pending <= pending - PW'(1);
            end

            case (state)
                IDLE: if (acc && w_sop && !w_eop) state <= sel_inj ? INJ : PASS;
                PASS: if (acc && w_eop) state <= IDLE;
                INJ:  if (acc && w_eop) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
